// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if -- request/response bundle for the iterative integer divider.
//
// Signals
//   in_valid  : request present                      (master -> slave)
//   in_ready  : divider can accept a request         (slave  -> master)
//   op        : {is_word, is_unsigned, is_rem}       (master -> slave)
//   rs1, rs2  : dividend, divisor                    (master -> slave)
//   flush     : abort whatever is in flight          (master -> slave)
//   out_valid : result available                     (slave  -> master)
//   out_ready : consumer takes the result            (master -> slave)
//   result    : quotient or remainder                (slave  -> master)
//   busy      : divider is not idle                  (slave  -> master)
// -----------------------------------------------------------------------------
interface div_unit_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport slave (
        input  in_valid, op, rs1, rs2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );

    modport master (
        output in_valid, op, rs1, rs2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- multi-cycle restoring radix-2 integer divider for RV64M
// div/divu/rem/remu and their word forms divw/divuw/remw/remuw.
//
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : div_unit_if.slave (request, flush, response handshake, busy)
//
// Flow
//   IDLE -> PREP -> CALC (64 or 32 iterations) -> FIX -> DONE -> IDLE
//   Divide-by-zero and signed overflow are resolved at acceptance and jump
//   straight from IDLE to DONE. flush returns to IDLE from any state.
//
// Datapath
//   dvd_q holds the dividend magnitude and collects quotient bits in its LSB
//   as the dividend shifts out of its MSB. Word operands are pre-shifted into
//   the upper half so that 32 iterations leave the quotient in the low half.
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int XLEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    div_unit_if.slave  bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int HALF = XLEN / 2;

    // Sign-extend the low half of a value to full width.
    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        sext_word = {{HALF{v[HALF-1]}}, v[HALF-1:0]};
    endfunction

    // Zero-extend the low half of a value to full width.
    function automatic logic [XLEN-1:0] zext_word(input logic [XLEN-1:0] v);
        zext_word = {{HALF{1'b0}}, v[HALF-1:0]};
    endfunction

    // Two's complement negation when neg is set.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                 input logic            neg);
        cond_neg = neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    logic [2:0]      state_q,     state_d;
    logic [2:0]      op_q,        op_d;
    logic [XLEN-1:0] dvd_q,       dvd_d;
    logic [XLEN-1:0] dvs_q,       dvs_d;
    logic [XLEN-1:0] rem_q,       rem_d;
    logic [5:0]      cnt_q,       cnt_d;
    logic            q_neg_q,     q_neg_d;
    logic            r_neg_q,     r_neg_d;
    logic [XLEN-1:0] result_q,    result_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q;

    logic            in_ready_s;
    logic [XLEN-1:0] a_ext_s;
    logic [XLEN-1:0] b_ext_s;
    logic [XLEN-1:0] spec_dvd_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic [XLEN:0]   shifted_s;
    logic [XLEN:0]   diff_s;
    logic [XLEN-1:0] mag_a_s;
    logic [XLEN-1:0] mag_b_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] fix_res_s;

    // in_ready is gated by rst_n so every output reads 0 while reset is held,
    // yet it rises in the very first cycle after release.
    assign in_ready_s    = (state_q == S_IDLE) && !bus.flush && rst_n;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;

    // Operand extension and special-case detection on the incoming request.
    always_comb begin
        a_ext_s    = bus.rs1;
        b_ext_s    = bus.rs2;
        spec_dvd_s = bus.rs1;
        if (bus.op[2]) begin
            a_ext_s    = bus.op[1] ? zext_word(bus.rs1) : sext_word(bus.rs1);
            b_ext_s    = bus.op[1] ? zext_word(bus.rs2) : sext_word(bus.rs2);
            // Special-case word results always come back sign-extended.
            spec_dvd_s = sext_word(bus.rs1);
        end else begin
            a_ext_s    = bus.rs1;
            b_ext_s    = bus.rs2;
            spec_dvd_s = bus.rs1;
        end
        div_zero_s = (b_ext_s == {XLEN{1'b0}});
        if (bus.op[2]) begin
            ovf_s = !bus.op[1] && (b_ext_s == {XLEN{1'b1}}) &&
                    (a_ext_s == {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}});
        end else begin
            ovf_s = !bus.op[1] && (b_ext_s == {XLEN{1'b1}}) &&
                    (a_ext_s == {1'b1, {(XLEN-1){1'b0}}});
        end
    end

    // Per-stage arithmetic: magnitudes, one restoring step, final sign fix.
    always_comb begin
        a_neg_s   = !op_q[1] && dvd_q[XLEN-1];
        b_neg_s   = !op_q[1] && dvs_q[XLEN-1];
        mag_a_s   = cond_neg(dvd_q, a_neg_s);
        mag_b_s   = cond_neg(dvs_q, b_neg_s);
        shifted_s = {rem_q, dvd_q[XLEN-1]};
        diff_s    = shifted_s - {1'b0, dvs_q};
        if (op_q[0]) begin
            fix_res_s = cond_neg(rem_q, r_neg_q);
        end else begin
            fix_res_s = cond_neg(dvd_q, q_neg_q);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        if (bus.flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            result_d    = {XLEN{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_s) begin
                        op_d  = bus.op;
                        dvd_d = a_ext_s;
                        dvs_d = b_ext_s;
                        if (div_zero_s) begin
                            result_d    = bus.op[0] ? spec_dvd_s : {XLEN{1'b1}};
                            out_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end else if (ovf_s) begin
                            result_d    = bus.op[0] ? {XLEN{1'b0}} : spec_dvd_s;
                            out_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            state_d = S_PREP;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PREP: begin
                    // Word magnitudes fit in the low half, so shift them up.
                    if (op_q[2]) begin
                        dvd_d = mag_a_s << HALF;
                        cnt_d = 6'd31;
                    end else begin
                        dvd_d = mag_a_s;
                        cnt_d = 6'd63;
                    end
                    dvs_d   = mag_b_s;
                    rem_d   = {XLEN{1'b0}};
                    q_neg_d = a_neg_s ^ b_neg_s;
                    r_neg_d = a_neg_s;
                    state_d = S_CALC;
                end
                S_CALC: begin
                    // diff_s[XLEN] set means the trial subtraction borrowed.
                    if (diff_s[XLEN]) begin
                        rem_d = shifted_s[XLEN-1:0];
                        dvd_d = {dvd_q[XLEN-2:0], 1'b0};
                    end else begin
                        rem_d = diff_s[XLEN-1:0];
                        dvd_d = {dvd_q[XLEN-2:0], 1'b1};
                    end
                    if (cnt_q == 6'd0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
                S_FIX: begin
                    if (op_q[2]) begin
                        result_d = sext_word(fix_res_s);
                    end else begin
                        result_d = fix_res_s;
                    end
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            dvd_q       <= {XLEN{1'b0}};
            dvs_q       <= {XLEN{1'b0}};
            rem_q       <= {XLEN{1'b0}};
            cnt_q       <= 6'd0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            result_q    <= {XLEN{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- directed and random checks of div_unit: results, latency,
// special cases, output hold, flush and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_unit_if #(.XLEN(64)) bus ();
    div_unit #(.XLEN(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    int          lat_q[$];

    localparam logic [2:0] OP_DIV   = 3'b000;
    localparam logic [2:0] OP_REM   = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_REMU  = 3'b011;
    localparam logic [2:0] OP_DIVUW = 3'b110;
    localparam logic [2:0] OP_REMW  = 3'b101;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Reference model built on the simulator's own / and % operators.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic [31:0] ua, ub, wr;
        int          wa, wb;
        longint      sa, sb;
        logic [63:0] r64;
        if (op[2]) begin
            ua = a[31:0];
            ub = b[31:0];
            if (ub == 32'd0)                                            wr = op[0] ? ua : 32'hFFFF_FFFF;
            else if (!op[1] && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) wr = op[0] ? 32'd0 : ua;
            else if (op[1])                                             wr = op[0] ? (ua % ub) : (ua / ub);
            else begin
                wa = ua;
                wb = ub;
                wr = op[0] ? (wa % wb) : (wa / wb);
            end
            return {{32{wr[31]}}, wr};
        end
        if (b == 64'd0)                                                  r64 = op[0] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (!op[1] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r64 = op[0] ? 64'd0 : a;
        else if (op[1])                                                  r64 = op[0] ? (a % b) : (a / b);
        else begin
            sa  = a;
            sb  = b;
            r64 = op[0] ? (sa % sb) : (sa / sb);
        end
        return r64;
    endfunction

    task automatic start(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        check("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.rs1      = a;
        bus.rs2      = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // lat0 = acceptance edge plus any edges already consumed by the caller.
    task automatic wait_out(input string tag, input int lat0);
        int lat = lat0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(lat_q.pop_front()));
        check({tag, "_res"}, bus.result, exp_q.pop_front());
    endtask

    task automatic release_out();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("released_valid", {63'd0, bus.out_valid}, 64'd0);
        check("released_busy", {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic issue(input string tag, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat);
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        start(op, a, b);
        wait_out(tag, 1);
        release_out();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen;
        logic [2:0]  rop;
        logic [63:0] ra, rb;
        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.rs1       = 64'd0;
        bus.rs2       = 64'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #12;
        check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_result", bus.result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // divu 100/7 with stray requests while busy; they must be ignored.
        exp_q.push_back(64'd14);
        lat_q.push_back(67);
        start(OP_DIVU, 64'd100, 64'd7);
        check("busy_prep", {63'd0, bus.busy}, 64'd1);
        bus.in_valid = 1'b1;
        bus.op       = OP_REMU;
        bus.rs1      = 64'd5;
        bus.rs2      = 64'd1;
        repeat (5) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_out("divu_100_7", 6);
        release_out();

        issue("remu_100_7", OP_REMU, 64'd100, 64'd7, 64'd2, 67);
        issue("div_m7_2", OP_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67);
        issue("rem_m7_2", OP_REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67);
        issue("div_by0", OP_DIV, 64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        issue("rem_5_by0", OP_REM, 64'd5, 64'd0, 64'd5, 1);
        issue("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 1);
        issue("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        issue("divuw_sx", OP_DIVUW, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 35);
        issue("remw_m7_3", OP_REMW, -64'sd7, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 35);
        issue("divw_ovf", 3'b100, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 1);
        issue("remuw_by0", 3'b111, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000,
              64'hFFFF_FFFF_8000_0001, 1);

        // Hold in DONE for 10 cycles with a competing request on the bus.
        exp_q.push_back(64'd100);
        lat_q.push_back(67);
        start(OP_DIVU, 64'd1000, 64'd10);
        wait_out("hold", 1);
        bus.in_valid = 1'b1;
        bus.rs1      = 64'd77;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_result", bus.result, 64'd100);
            check("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
            check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
        end
        bus.in_valid = 1'b0;
        release_out();

        // Asynchronous reset in the middle of CALC.
        start(OP_DIV, 64'd999, 64'd3);
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        check("midrst_result", bus.result, 64'd0);
        check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Flush at CALC cycle 20: back to IDLE, no result ever appears.
        start(OP_DIVU, 64'd100, 64'd7);
        repeat (20) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy", {63'd0, bus.busy}, 64'd0);
        check("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        seen = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        check("flush_no_valid", 64'(seen), 64'd0);

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("flush_in_ready", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("flush_no_accept", {63'd0, bus.busy}, 64'd0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;

        // Random operations against the model.
        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (rb[31:0] == 32'd0) rb[0] = 1'b1;
            if (rb == 64'hFFFF_FFFF_FFFF_FFFF || rb[31:0] == 32'hFFFF_FFFF) rb[1] = 1'b0;
            issue("rand", rop, ra, rb, model(rop, ra, rb), rop[2] ? 35 : 67);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
